register_bank_sb: RTL and testbench
===================================

Name: register_bank_sb

Overview:
- Parametrised successor to the 8x8 register bank used by the datapath.
- Width, depth and two read ports are configurable; one write port.
- Adds asynchronous reset of all registers, an optional hardwired-zero r0, optional write-to-read bypass, and a per-register pending scoreboard.
- Sits between decode (read/issue) and writeback in the pipelined core.

Parameters:
- WIDTH, 8, register data width in bits.
- DEPTH, 8, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), register index width (derived localparam).
- ZERO_R0, 0, 1 = r0 reads as 0 always and ignores writes and issues.
- BYPASS, 1, 1 = a read of the register being written this cycle returns d.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ri_a  in  AW  read port A index.
- ri_b  in  AW  read port B index.
- a  out  WIDTH  read port A data (combinational).
- b  out  WIDTH  read port B data (combinational).
- rw  in  1  write enable.
- ri_d  in  AW  write index.
- d  in  WIDTH  write data.
- pv  in  1  issue strobe: mark register ri_p pending.
- ri_p  in  AW  issue destination index.
- busy_a  out  1  register ri_a is pending (combinational).
- busy_b  out  1  register ri_b is pending (combinational).
- pend_cnt  out  AW+1  number of pending registers (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers go to 0, all pending bits clear, pend_cnt = 0.
  - a and b read 0 while reset is asserted.
  - Reset asserted mid-write: the write is lost.
- Write: on the rising edge with rw=1, reg[ri_d] <= d.
  - With ZERO_R0=1 and ri_d=0, nothing is stored.
- Read: a = reg[ri_a], b = reg[ri_b], combinational with no clock latency.
  - With ZERO_R0=1, index 0 reads 0.
  - With BYPASS=1, rw=1 and ri_a==ri_d (not the zeroed r0), a = d in the same cycle. Port b behaves the same way.
  - With BYPASS=0, the old value is returned until the edge; the new value is visible from the next cycle.
  - Both ports may read the same index.
- Scoreboard, per-register pending bit p[i]:
  - Rising edge with pv=1: p[ri_p] <= 1.
  - Rising edge with rw=1: p[ri_d] <= 0 (writeback retires).
  - pv and rw targeting the same index on the same edge: set wins (p=1; new producer issued).
  - pv and rw targeting different indices: both take effect.
  - pv to an already-pending register: stays 1, count unchanged.
  - rw to a non-pending register: data is written, p stays 0, count unchanged.
  - ZERO_R0=1: p[0] is constantly 0.
- Busy outputs: busy_a = p[ri_a], busy_b = p[ri_b].
  - Writeback bypass does not clear busy in the same cycle; busy reflects registered state.
- pend_cnt: population count of p, updated on the same edge as p.
  - Net change per edge is in {-1, 0, +1, 0 for set+clear on different indices}.
  - Range 0..DEPTH; must never wrap.
- Out-of-range indices cannot occur because DEPTH is a power of two.

Test Plan:
- Reset/write/read: release rst_n; write r0<=7, r1<=5 (ZERO_R0=0); set ri_a=0, ri_b=1 -> a=7, b=5. Assert rst_n low mid-cycle -> a=0, b=0 immediately.
- Bypass: BYPASS=1, rw=1, ri_d=3, d=8'hA5, ri_a=3 before the edge -> a=8'hA5 in the same cycle. Repeat with BYPASS=0 -> a shows the old value (0), then 8'hA5 after the edge.
- Zero register: ZERO_R0=1, write r0<=8'hFF, pv with ri_p=0 -> a(ri_a=0)=0, busy_a=0, pend_cnt=0.
- Scoreboard lifecycle: pv ri_p=2, then pv ri_p=4 -> pend_cnt=2, busy on 2 and 4. Write r2 -> busy(2)=0, pend_cnt=1.
- Simultaneous events: p[5]=1; same edge pv ri_p=5 and rw ri_d=5 -> p[5]=1, pend_cnt unchanged. Same edge pv ri_p=6 and rw ri_d=4 (pending) -> pend_cnt unchanged, p[6]=1, p[4]=0.
- Parametrisation/saturation: WIDTH=16, DEPTH=4; issue all 4 then issue r1 again -> pend_cnt=4 (no wrap). Write 16'hBEEF to r3 -> b(ri_b=3)=16'hBEEF.

Source files
------------

// File: rtl/register_bank_sb.sv
// Parametrised register bank with async reset, optional zero r0,
// write-to-read bypass and a per-register pending scoreboard.
module register_bank_sb #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ri_a,
    input  logic [AW-1:0]    ri_b,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             rw,
    input  logic [AW-1:0]    ri_d,
    input  logic [WIDTH-1:0] d,
    input  logic             pv,
    input  logic [AW-1:0]    ri_p,
    output logic             busy_a,
    output logic             busy_b,
    output logic [AW:0]      pend_cnt
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] p_q, p_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_en, iss_en;
    logic             zero_a, zero_b;

    assign wr_en  = rw && !(ZERO_R0 != 0 && ri_d == '0);
    assign iss_en = pv && !(ZERO_R0 != 0 && ri_p == '0);
    assign zero_a = (ZERO_R0 != 0) && (ri_a == '0);
    assign zero_b = (ZERO_R0 != 0) && (ri_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[ri_d] <= d;
        end
    end

    // Issue is applied after retire so a same-index pair leaves p set.
    always_comb begin
        p_d = p_q;
        if (wr_en)  p_d[ri_d] = 1'b0;
        if (iss_en) p_d[ri_p] = 1'b1;
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (AW+1)'(p_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        a = '0;
        if (rst_n && !zero_a) begin
            if (BYPASS != 0 && wr_en && ri_a == ri_d) a = d;
            else                                     a = mem_q[ri_a];
        end
    end

    always_comb begin
        b = '0;
        if (rst_n && !zero_b) begin
            if (BYPASS != 0 && wr_en && ri_b == ri_d) b = d;
            else                                     b = mem_q[ri_b];
        end
    end

    assign busy_a   = p_q[ri_a];
    assign busy_b   = p_q[ri_b];
    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_register_bank_sb.sv
// Directed bench for register_bank_sb across three parameter sets.
module tb_register_bank_sb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ri_a, ri_b, ri_d, ri_p;
    logic       rw, pv;
    logic [7:0] d;

    logic [7:0] a0, b0, a1, b1;
    logic       ba0, bb0, ba1, bb1;
    logic [3:0] pc0, pc1;

    logic [1:0]  s_ri_a, s_ri_b, s_ri_d, s_ri_p;
    logic        s_rw, s_pv;
    logic [15:0] s_d, a2, b2;
    logic        ba2, bb2;
    logic [2:0]  pc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    register_bank_sb u0 (
        .clk(clk), .rst_n(rst_n), .ri_a(ri_a), .ri_b(ri_b),
        .a(a0), .b(b0), .rw(rw), .ri_d(ri_d), .d(d),
        .pv(pv), .ri_p(ri_p), .busy_a(ba0), .busy_b(bb0),
        .pend_cnt(pc0)
    );

    register_bank_sb #(.ZERO_R0(1), .BYPASS(0)) u1 (
        .clk(clk), .rst_n(rst_n), .ri_a(ri_a), .ri_b(ri_b),
        .a(a1), .b(b1), .rw(rw), .ri_d(ri_d), .d(d),
        .pv(pv), .ri_p(ri_p), .busy_a(ba1), .busy_b(bb1),
        .pend_cnt(pc1)
    );

    register_bank_sb #(.WIDTH(16), .DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .ri_a(s_ri_a), .ri_b(s_ri_b),
        .a(a2), .b(b2), .rw(s_rw), .ri_d(s_ri_d), .d(s_d),
        .pv(s_pv), .ri_p(s_ri_p), .busy_a(ba2), .busy_b(bb2),
        .pend_cnt(pc2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fall();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        {ri_a, ri_b, ri_d, ri_p} = '0;
        {rw, pv} = '0;
        d = '0;
        {s_ri_a, s_ri_b, s_ri_d, s_ri_p} = '0;
        {s_rw, s_pv} = '0;
        s_d = '0;

        #2;
        check("rst_a", a0, 0);
        check("rst_cnt", pc0, 0);
        fall();
        rst_n = 1'b1;

        // write r0<=7, r1<=5
        rw = 1; ri_d = 0; d = 8'd7;
        tick();
        fall();
        ri_d = 1; d = 8'd5;
        tick();
        fall();
        rw = 0; ri_a = 0; ri_b = 1;
        #1;
        check("rd_a", a0, 7);
        check("rd_b", b0, 5);
        check("z_rd_a", a1, 0);
        check("z_rd_b", b1, 5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_a", a0, 0);
        check("rst_mid_b", b0, 0);
        fall();
        rst_n = 1'b1;
        #1;
        check("rst_lost", b0, 0);

        // bypass on u0, none on u1
        fall();
        rw = 1; ri_d = 3; d = 8'hA5; ri_a = 3; ri_b = 3;
        #1;
        check("byp_a", a0, 8'hA5);
        check("byp_b", b0, 8'hA5);
        check("nobyp_a", a1, 0);
        tick();
        fall();
        rw = 0;
        #1;
        check("nobyp_after", a1, 8'hA5);

        // zero register and same-index issue/retire on r0
        fall();
        rw = 1; ri_d = 0; d = 8'hFF; pv = 1; ri_p = 0;
        tick();
        fall();
        rw = 0; pv = 0; ri_a = 0;
        #1;
        check("z_a", a1, 0);
        check("z_busy", ba1, 0);
        check("z_cnt", pc1, 0);
        check("r0_a", a0, 8'hFF);
        check("r0_busy", ba0, 1);
        check("r0_cnt", pc0, 1);

        // scoreboard lifecycle
        rst_n = 0;
        #1;
        check("rst_cnt2", pc0, 0);
        fall();
        rst_n = 1;
        pv = 1; ri_p = 2;
        tick();
        fall();
        ri_p = 4;
        tick();
        fall();
        pv = 0; ri_a = 2; ri_b = 4;
        #1;
        check("sb_cnt2", pc0, 2);
        check("sb_b2", ba0, 1);
        check("sb_b4", bb0, 1);
        check("sb_cnt2_z", pc1, 2);
        rw = 1; ri_d = 2; d = 8'h11;
        #1;
        check("sb_busy_hold", ba0, 1);
        tick();
        fall();
        rw = 0;
        #1;
        check("sb_ret_busy", ba0, 0);
        check("sb_ret_cnt", pc0, 1);
        check("sb_ret_z", ba1, 0);

        // simultaneous events
        pv = 1; ri_p = 5;
        tick();
        fall();
        check("sim_cnt0", pc0, 2);
        rw = 1; ri_d = 5;
        tick();
        fall();
        pv = 0; rw = 0; ri_a = 5;
        #1;
        check("sim_same_busy", ba0, 1);
        check("sim_same_cnt", pc0, 2);
        pv = 1; ri_p = 6; rw = 1; ri_d = 4;
        tick();
        fall();
        pv = 0; rw = 0; ri_a = 6; ri_b = 4;
        #1;
        check("sim_diff_b6", ba0, 1);
        check("sim_diff_b4", bb0, 0);
        check("sim_diff_cnt", pc0, 2);
        rw = 1; ri_d = 7;
        tick();
        fall();
        rw = 0;
        #1;
        check("ret_idle_cnt", pc0, 2);

        // 16x4 saturation
        for (int i = 0; i < 4; i++) begin
            s_pv = 1; s_ri_p = 2'(i);
            tick();
            fall();
        end
        s_ri_p = 1;
        tick();
        fall();
        s_pv = 0;
        #1;
        check("w16_full", pc2, 4);
        s_rw = 1; s_ri_d = 3; s_d = 16'hBEEF; s_ri_b = 3;
        #1;
        check("w16_byp", b2, 16'hBEEF);
        tick();
        fall();
        s_rw = 0;
        #1;
        check("w16_b", b2, 16'hBEEF);
        check("w16_cnt", pc2, 3);
        check("w16_busy3", bb2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
